seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the board's 4-digit common-anode 7-segment display. It holds a 4-digit hex/BCD value and drives one digit at a time onto the shared segment bus. Each digit slot has a blanking gap before it to suppress ghosting. New values are written over a ready/enable handshake and take effect only on a frame boundary, so the display never tears. It sits between the counter or stopwatch datapath and the nSEG/nAN pins, and runs on the 50 MHz system clock.

---
 rtl/seg7_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// Values are double-buffered and committed only on frame boundaries to avoid tearing.
module seg7_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  output logic        wr_ready,
  input  logic        lz_blank,
  output logic        frame_tick,
  output logic [7:0]  nSEG,
  output logic [3:0]  nAN
);

  localparam int unsigned MaxCyc = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [CntW-1:0] BlankLast   = CntW'(BLANK_CYC - 1);
  localparam logic [CntW-1:0] ShowLast    = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] ShowPreLast = CntW'(SCAN_DIV - 2);

  typedef enum logic [0:0] {StBlank, StShow} state_e;

  state_e          state_q;
  logic [1:0]      idx_q;
  logic [CntW-1:0] cnt_q;
  logic [15:0]     active_val_q;
  logic [3:0]      active_dp_q;
  logic [15:0]     pend_val_q;
  logic [3:0]      pend_dp_q;
  logic            pend_full_q;
  logic            frame_tick_q;
  logic [7:0]      nseg_q;
  logic [3:0]      nan_q;

  logic [3:0]      cur_digit;
  logic            cur_dp;
  logic [3:0]      dig_zero;
  logic [3:0]      lz_mask;
  logic            cur_blank;
  logic [7:0]      cur_seg;

  // Active-low gfedcba pattern with the dp bit left off (bit 7 = 1).
  function automatic logic [7:0] seg7(input logic [3:0] d);
    unique case (d)
      4'h0: seg7 = 8'hC0;
      4'h1: seg7 = 8'hF9;
      4'h2: seg7 = 8'hA4;
      4'h3: seg7 = 8'hB0;
      4'h4: seg7 = 8'h99;
      4'h5: seg7 = 8'h92;
      4'h6: seg7 = 8'h82;
      4'h7: seg7 = 8'hD8;
      4'h8: seg7 = 8'h80;
      4'h9: seg7 = 8'h90;
      4'hA: seg7 = 8'h88;
      4'hB: seg7 = 8'h83;
      4'hC: seg7 = 8'hC6;
      4'hD: seg7 = 8'hA1;
      4'hE: seg7 = 8'h86;
      default: seg7 = 8'h8E;
    endcase
  endfunction

  always_comb begin
    cur_digit = 4'(active_val_q >> {idx_q, 2'b00});
    cur_dp    = active_dp_q[idx_q];
    for (int i = 0; i < 4; i++) begin
      dig_zero[i] = (active_val_q[4*i +: 4] == 4'h0);
    end
    // A digit is a leading zero only if it and every higher digit are zero.
    lz_mask[3] = dig_zero[3];
    lz_mask[2] = dig_zero[3] & dig_zero[2];
    lz_mask[1] = dig_zero[3] & dig_zero[2] & dig_zero[1];
    lz_mask[0] = 1'b0;
    cur_blank  = lz_blank & lz_mask[idx_q];
    cur_seg    = seg7(cur_digit);
    cur_seg[7] = ~cur_dp;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StBlank;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      active_val_q <= 16'h0000;
      active_dp_q  <= 4'h0;
      pend_val_q   <= 16'h0000;
      pend_dp_q    <= 4'h0;
      pend_full_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      nseg_q       <= 8'hFF;
      nan_q        <= 4'hF;
    end else begin
      unique case (state_q)
        StBlank: begin
          if (cnt_q == BlankLast) begin
            state_q <= StShow;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          if (cnt_q == ShowLast) begin
            state_q <= StBlank;
            cnt_q   <= '0;
            idx_q   <= idx_q + 2'd1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase

      // Registered so it is high exactly during the last SHOW cycle of digit 3.
      frame_tick_q <= (state_q == StShow) && (idx_q == 2'd3) && (cnt_q == ShowPreLast);

      if (frame_tick_q && pend_full_q) begin
        active_val_q <= pend_val_q;
        active_dp_q  <= pend_dp_q;
        pend_full_q  <= 1'b0;
      end else if (wr_en && !pend_full_q) begin
        pend_val_q  <= wr_data;
        pend_dp_q   <= wr_dp;
        pend_full_q <= 1'b1;
      end

      if ((state_q == StShow) && !cur_blank) begin
        nan_q        <= 4'hF;
        nan_q[idx_q] <= 1'b0;
        nseg_q       <= cur_seg;
      end else begin
        nan_q  <= 4'hF;
        nseg_q <= 8'hFF;
      end
    end
  end

  assign wr_ready   = ~pend_full_q;
  assign frame_tick = frame_tick_q;
  assign nSEG       = nseg_q;
  assign nAN        = nan_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with a short scan (SCAN_DIV=4, BLANK_CYC=2).
// Each frame record lists the writes issued during it and the digits it must display.
module tb_seg7_scan_ctrl;

  localparam int SD   = 4;
  localparam int BC   = 2;
  localparam int SLOT = SD + BC;
  localparam int FL   = 4 * SLOT;

  typedef struct {
    int          wa;
    logic [15:0] da;
    logic [3:0]  pa;
    int          wb;
    logic [15:0] db;
    logic [3:0]  pb;
    logic        lz;
    logic [31:0] seg;   // {digit3, digit2, digit1, digit0} expected nSEG
    logic [3:0]  blk;   // digits expected fully dark in their SHOW slot
  } frame_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = 16'h0000;
  logic [3:0]  wr_dp = 4'h0;
  logic        lz_blank = 1'b0;
  logic        wr_ready;
  logic        frame_tick;
  logic [7:0]  nSEG;
  logic [3:0]  nAN;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit pend  = 1'b0;

  frame_t frames [9];

  seg7_scan_ctrl #(
    .SCAN_DIV  (SD),
    .BLANK_CYC (BC)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .wr_ready   (wr_ready),
    .lz_blank   (lz_blank),
    .frame_tick (frame_tick),
    .nSEG       (nSEG),
    .nAN        (nAN)
  );

  always #5 CLK = ~CLK;

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_reset_state();
    chk8("rst_nAN", {4'h0, nAN}, 8'h0F);
    chk8("rst_nSEG", nSEG, 8'hFF);
    chk8("rst_wr_ready", {7'b0, wr_ready}, 8'h01);
    chk8("rst_frame_tick", {7'b0, frame_tick}, 8'h00);
  endtask

  task automatic step(input frame_t f, input logic en, input logic [15:0] d,
                      input logic [3:0] p);
    int pp, s, q;
    logic [3:0] an_e;
    logic [7:0] seg_e;
    bit commit, accept;
    wr_en    = en;
    wr_data  = d;
    wr_dp    = p;
    lz_blank = f.lz;
    @(posedge CLK);
    #1;
    cyc++;
    commit = ((cyc % FL) == 0) && pend;
    accept = en && !pend;
    if (accept) pend = 1'b1;
    else if (commit) pend = 1'b0;
    wr_en = 1'b0;
    pp = (cyc - 1) % FL;
    s  = pp / SLOT;
    q  = pp % SLOT;
    an_e  = 4'hF;
    seg_e = 8'hFF;
    if (q >= BC && !f.blk[s]) begin
      an_e[s] = 1'b0;
      seg_e   = f.seg[8*s +: 8];
    end
    chk8("nAN", {4'h0, nAN}, {4'h0, an_e});
    chk8("nSEG", nSEG, seg_e);
    chk8("frame_tick", {7'b0, frame_tick}, ((cyc % FL) == FL - 1) ? 8'h01 : 8'h00);
    chk8("wr_ready", {7'b0, wr_ready}, pend ? 8'h00 : 8'h01);
  endtask

  task automatic run_frame(input frame_t f);
    for (int pos = 1; pos <= FL; pos++) begin
      if (pos == f.wa) step(f, 1'b1, f.da, f.pa);
      else if (pos == f.wb) step(f, 1'b1, f.db, f.pb);
      else step(f, 1'b0, 16'h0000, 4'h0);
    end
  endtask

  initial begin
    // Writes land during the listed frame; seg/blk describe what that frame displays.
    frames[0] = '{10, 16'h1234, 4'b0100, 15, 16'h5678, 4'h0, 1'b0, 32'hC0C0C0C0, 4'h0};
    frames[1] = '{3,  16'h5678, 4'h0,    0,  16'h0000, 4'h0, 1'b0, 32'hF924B099, 4'h0};
    frames[2] = '{24, 16'hABCD, 4'h0,    0,  16'h0000, 4'h0, 1'b0, 32'h9282D880, 4'h0};
    frames[3] = '{0,  16'h0000, 4'h0,    0,  16'h0000, 4'h0, 1'b0, 32'h9282D880, 4'h0};
    frames[4] = '{5,  16'h0050, 4'b1000, 0,  16'h0000, 4'h0, 1'b1, 32'h8883C6A1, 4'h0};
    frames[5] = '{5,  16'h0000, 4'h0,    0,  16'h0000, 4'h0, 1'b1, 32'hFFFF92C0, 4'b1100};
    frames[6] = '{3,  16'h1234, 4'h0,    0,  16'h0000, 4'h0, 1'b1, 32'hFFFFFFC0, 4'b1110};
    frames[7] = '{2,  16'h9999, 4'h0,    0,  16'h0000, 4'h0, 1'b0, 32'hF9A4B099, 4'h0};
    frames[8] = '{0,  16'h0000, 4'h0,    0,  16'h0000, 4'h0, 1'b0, 32'hC0C0C0C0, 4'h0};

    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk_reset_state();
    RST  = 1'b0;
    cyc  = 0;
    pend = 1'b0;

    for (int i = 0; i < 7; i++) run_frame(frames[i]);

    // Frame 7: fill pending, then reset in the middle of digit 2's SHOW slot.
    for (int pos = 1; pos <= 16; pos++) begin
      step(frames[7], pos == 2, 16'h9999, 4'h0);
    end
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk_reset_state();
    RST  = 1'b0;
    cyc  = 0;
    pend = 1'b0;

    // Scan restarts at digit 0 with active cleared and the dropped write never appearing.
    run_frame(frames[8]);
    run_frame(frames[8]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
